stopwatch_ctrl: RTL and testbench

//  Front-end controller for the stopwatch seconds counter. Synchronises and

---
 rtl/stopwatch_ctrl_if.sv | 24 ++
 rtl/stopwatch_ctrl.sv | 130 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Button/counter side bundle for the stopwatch front-end controller.
// master = board/testbench side, slave = stopwatch_ctrl.
interface stopwatch_ctrl_if #(
    parameter int CNT_W = 19
);
    logic             btn_start_stop;
    logic             btn_clear;
    logic             btn_lap;
    logic [CNT_W-1:0] sec_count;
    logic [1:0]       en;
    logic             running;
    logic             lap_hold;
    logic [CNT_W-1:0] lap_value;

    modport master (
        output btn_start_stop, btn_clear, btn_lap, sec_count,
        input  en, running, lap_hold, lap_value
    );

    modport slave (
        input  btn_start_stop, btn_clear, btn_lap, sec_count,
        output en, running, lap_hold, lap_value
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-end: synchronise and debounce three buttons, run the
// IDLE/RUN/PAUSE mode machine and hold a lap snapshot of the seconds counter.
module stopwatch_ctrl #(
    parameter int DEB_CYCLES = 500_000,
    parameter int CNT_W      = 19
) (
    input logic             clk,
    input logic             hard_reset,
    stopwatch_ctrl_if.slave bus
);
    localparam int            CW      = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;

    // Bit order everywhere: [0] start/stop, [1] clear, [2] lap
    logic [2:0]    raw;
    logic [2:0]    sync1_q, sync2_q;
    logic [2:0]    deb_q, deb_d, deb_dly_q;
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];
    logic [2:0]    press;

    logic [1:0]       state_q, state_d;
    logic             lap_hold_q, lap_hold_d;
    logic [CNT_W-1:0] lap_value_q, lap_value_d;

    assign raw = {bus.btn_lap, bus.btn_clear, bus.btn_start_stop};

    // A level is accepted only after DEB_CYCLES consecutive cycles of disagreement
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge hard_reset) begin
        if (hard_reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            deb_dly_q <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign press = deb_q & ~deb_dly_q;

    always_comb begin
        state_d     = state_q;
        lap_hold_d  = lap_hold_q;
        lap_value_d = lap_value_q;
        case (state_q)
            S_IDLE: begin
                if (press[0]) state_d = S_RUN;
            end
            S_RUN: begin
                if (press[2]) begin
                    if (!lap_hold_q) begin
                        lap_value_d = bus.sec_count;
                        lap_hold_d  = 1'b1;
                    end else begin
                        lap_hold_d = 1'b0;
                    end
                end
                if (press[0]) state_d = S_PAUSE;
            end
            S_PAUSE: begin
                // Clear wins over start/stop; entering IDLE drops the lap snapshot
                if (press[1]) begin
                    state_d     = S_IDLE;
                    lap_hold_d  = 1'b0;
                    lap_value_d = '0;
                end else if (press[0]) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d     = S_IDLE;
                lap_hold_d  = 1'b0;
                lap_value_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge hard_reset) begin
        if (hard_reset) begin
            state_q     <= S_IDLE;
            lap_hold_q  <= 1'b0;
            lap_value_q <= '0;
        end else begin
            state_q     <= state_d;
            lap_hold_q  <= lap_hold_d;
            lap_value_q <= lap_value_d;
        end
    end

    always_comb begin
        bus.en      = 2'b00;
        bus.running = 1'b0;
        case (state_q)
            S_RUN:   begin bus.en = 2'b01; bus.running = 1'b1; end
            S_PAUSE: bus.en = 2'b10;
            default: bus.en = 2'b00;
        endcase
    end

    assign bus.lap_hold  = lap_hold_q;
    assign bus.lap_value = lap_value_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: directed scenarios plus randomized
// button activity checked every cycle against a behavioural model.
module tb_stopwatch_ctrl;
    localparam int DEB = 4;
    localparam int CW  = 19;

    logic clk = 1'b0;
    logic hard_reset = 1'b0;
    always #5 clk = ~clk;

    stopwatch_ctrl_if #(.CNT_W(CW)) bus ();

    stopwatch_ctrl #(.DEB_CYCLES(DEB), .CNT_W(CW)) dut (
        .clk       (clk),
        .hard_reset(hard_reset),
        .bus       (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 run, 2 pause
    typedef struct packed {
        logic [1:0]    en;
        logic          running;
        logic          hold;
        logic [CW-1:0] val;
    } exp_t;

    exp_t          exp_q[$];
    int            m_mode;
    bit            m_hold;
    logic [CW-1:0] m_val;
    bit            m_deb  [3];
    int            m_run  [3];
    bit            m_pend [3];
    bit            m_hist [3][$];

    function automatic exp_t m_out();
        exp_t e;
        e.en      = 2'(m_mode);
        e.running = (m_mode == 1);
        e.hold    = m_hold;
        e.val     = m_val;
        return e;
    endfunction

    task automatic m_reset();
        m_mode = 0;
        m_hold = 0;
        m_val  = '0;
        for (int b = 0; b < 3; b++) begin
            m_deb[b]  = 0;
            m_run[b]  = 0;
            m_pend[b] = 0;
            m_hist[b].delete();
        end
    endtask

    task automatic m_step();
        bit raw [3];
        bit ss, clr, lap, s;
        raw[0] = bus.btn_start_stop;
        raw[1] = bus.btn_clear;
        raw[2] = bus.btn_lap;
        ss  = m_pend[0];
        clr = m_pend[1];
        lap = m_pend[2];
        case (m_mode)
            0: if (ss) m_mode = 1;
            1: begin
                if (lap) begin
                    if (!m_hold) begin
                        m_val  = bus.sec_count;
                        m_hold = 1;
                    end else begin
                        m_hold = 0;
                    end
                end
                if (ss) m_mode = 2;
            end
            default: begin
                if (clr) begin
                    m_mode = 0;
                    m_hold = 0;
                    m_val  = '0;
                end else if (ss) begin
                    m_mode = 1;
                end
            end
        endcase
        // A button level is seen two edges after it is sampled, then must persist DEB edges
        for (int b = 0; b < 3; b++) begin
            m_pend[b] = 0;
            s = (m_hist[b].size() >= 2) ? m_hist[b][m_hist[b].size()-2] : 1'b0;
            m_hist[b].push_back(raw[b]);
            if (m_hist[b].size() > 2) void'(m_hist[b].pop_front());
            if (s == m_deb[b]) begin
                m_run[b] = 0;
            end else begin
                m_run[b]++;
                if (m_run[b] == DEB) begin
                    m_deb[b] = s;
                    m_run[b] = 0;
                    if (s) m_pend[b] = 1;
                end
            end
        end
    endtask

    always @(posedge clk or posedge hard_reset) begin
        if (hard_reset) begin
            m_reset();
            exp_q.delete();
            exp_q.push_back(m_out());
        end else begin
            m_step();
            exp_q.push_back(m_out());
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_en",        32'(bus.en),        32'(e.en));
            chk("sb_running",   32'(bus.running),   32'(e.running));
            chk("sb_lap_hold",  32'(bus.lap_hold),  32'(e.hold));
            chk("sb_lap_value", 32'(bus.lap_value), 32'(e.val));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0:       bus.btn_start_stop = v;
            1:       bus.btn_clear      = v;
            default: bus.btn_lap        = v;
        endcase
    endtask

    task automatic do_reset();
        hard_reset = 1'b1;
        tick(2);
        hard_reset = 1'b0;
    endtask

    task automatic press(input int b);
        set_btn(b, 1'b1);
        tick(DEB + 4);
        set_btn(b, 1'b0);
        tick(DEB + 4);
    endtask

    int  remain [3];
    logic lvl   [3];

    initial begin
        bus.btn_start_stop = 1'b0;
        bus.btn_clear      = 1'b0;
        bus.btn_lap        = 1'b0;
        bus.sec_count      = '0;
        #1;
        do_reset();
        chk("reset_en",       32'(bus.en),        32'd0);
        chk("reset_lap_hold", 32'(bus.lap_hold),  32'd0);

        // Start latency: en changes exactly at edge DEB+3, once
        set_btn(0, 1'b1);
        tick(6);
        chk("t1_en_edge6", 32'(bus.en), 32'd0);
        tick(1);
        chk("t1_en_edge7",  32'(bus.en),      32'd1);
        chk("t1_running",   32'(bus.running), 32'd1);
        tick(13);
        chk("t1_en_held", 32'(bus.en), 32'd1);
        set_btn(0, 1'b0);
        tick(12);
        chk("t1_en_release", 32'(bus.en), 32'd1);

        // Short glitches never register
        do_reset();
        for (int w = 1; w <= 3; w++) begin
            set_btn(0, 1'b1);
            tick(w);
            set_btn(0, 1'b0);
            tick(10);
        end
        chk("t2_glitch_en", 32'(bus.en), 32'd0);

        // Pause keeps the lap snapshot; clear drops it
        do_reset();
        press(0);
        bus.sec_count = 19'd77;
        press(2);
        press(0);
        chk("t3_pause_en",   32'(bus.en),        32'd2);
        chk("t3_pause_hold", 32'(bus.lap_hold),  32'd1);
        chk("t3_pause_val",  32'(bus.lap_value), 32'd77);
        press(1);
        chk("t3_clear_en",   32'(bus.en),        32'd0);
        chk("t3_clear_hold", 32'(bus.lap_hold),  32'd0);
        chk("t3_clear_val",  32'(bus.lap_value), 32'd0);

        // Lap capture then release
        do_reset();
        press(0);
        bus.sec_count = 19'd1234;
        press(2);
        chk("t4_cap_hold", 32'(bus.lap_hold),  32'd1);
        chk("t4_cap_val",  32'(bus.lap_value), 32'd1234);
        bus.sec_count = 19'd2000;
        press(2);
        chk("t4_rel_hold", 32'(bus.lap_hold),  32'd0);
        chk("t4_rel_val",  32'(bus.lap_value), 32'd1234);

        // Clear beats start/stop in PAUSE; clear is ignored in RUN
        do_reset();
        press(0);
        press(0);
        set_btn(0, 1'b1);
        set_btn(1, 1'b1);
        tick(DEB + 4);
        chk("t5_clr_wins", 32'(bus.en), 32'd0);
        set_btn(0, 1'b0);
        set_btn(1, 1'b0);
        tick(DEB + 4);
        press(0);
        press(1);
        chk("t5_run_clr", 32'(bus.en), 32'd1);

        // Asynchronous reset in the middle of a debounce
        do_reset();
        press(0);
        bus.sec_count = 19'd555;
        press(2);
        chk("t6_pre_hold", 32'(bus.lap_hold), 32'd1);
        set_btn(0, 1'b1);
        tick(3);
        hard_reset = 1'b1;
        #1;
        chk("t6_async_en",   32'(bus.en),        32'd0);
        chk("t6_async_run",  32'(bus.running),   32'd0);
        chk("t6_async_hold", 32'(bus.lap_hold),  32'd0);
        chk("t6_async_val",  32'(bus.lap_value), 32'd0);
        set_btn(0, 1'b0);
        tick(1);
        hard_reset = 1'b0;
        tick(DEB + 6);
        chk("t6_after_en", 32'(bus.en), 32'd0);

        // Randomized button activity, scoreboard checks every cycle
        do_reset();
        for (int b = 0; b < 3; b++) begin
            remain[b] = 0;
            lvl[b]    = 1'b0;
        end
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (remain[b] == 0) begin
                    lvl[b]    = 1'($urandom_range(0, 1));
                    remain[b] = $urandom_range(1, 12);
                    set_btn(b, lvl[b]);
                end
                remain[b]--;
            end
            bus.sec_count = CW'($urandom);
            if ($urandom_range(0, 599) == 0) begin
                hard_reset = 1'b1;
                tick(1);
                hard_reset = 1'b0;
            end else begin
                tick(1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
